// File: rtl/kmeans_pkg.sv
// Shared types and constants for the k_means frame sequencer.
// Default seeds spread the centroid slots evenly across the frame at mid-height.
package kmeans_pkg;

  localparam int unsigned NUM_SLOTS  = 8;
  localparam int unsigned XW         = 11;
  localparam int unsigned YW         = 10;
  localparam int unsigned NBW        = 3;
  localparam int unsigned WIDTH      = 320;
  localparam int unsigned HEIGHT     = 180;
  localparam int unsigned CX_W       = NUM_SLOTS * XW;
  localparam int unsigned CY_W       = NUM_SLOTS * YW;
  localparam int unsigned SLOT_PITCH = WIDTH / NUM_SLOTS;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    STREAM,
    WAIT,
    PUBLISH
  } state_t;

  // Slot i sits at the centre of the i-th vertical strip: 20 + 40*i.
  function automatic logic [CX_W-1:0] def_seed_x();
    logic [CX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      v[i*XW +: XW] = XW'(SLOT_PITCH * i + SLOT_PITCH / 2);
    end
    return v;
  endfunction

  function automatic logic [CY_W-1:0] def_seed_y();
    logic [CY_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      v[i*YW +: YW] = YW'(HEIGHT / 2);
    end
    return v;
  endfunction

  localparam logic [CX_W-1:0] DEF_X = def_seed_x();
  localparam logic [CY_W-1:0] DEF_Y = def_seed_y();

endpackage

// File: rtl/kmeans_watchdog.sv
// Loadable down-counter; done pulses for one cycle after the count reaches zero while enabled.
module kmeans_watchdog #(
  parameter int unsigned CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      done  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      done  <= 1'b0;
    end else begin
      done <= en && (count == CNT_W'(1));
      if (en && (count != '0)) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/kmeans_sequencer.sv
// Per-frame controller for k_means: reset/seed, pixel gating, convergence watchdog
// and valid/ready publication of the centroid set, with warm-start seeding.
module kmeans_sequencer
  import kmeans_pkg::*;
#(
  parameter int unsigned MAX_BALLS      = NUM_SLOTS,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned RST_HOLD       = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    frame_start_in,
  input  logic                    pix_valid_in,
  input  logic [XW-1:0]           pix_x_in,
  input  logic [YW-1:0]           pix_y_in,
  input  logic [NBW-1:0]          num_balls_in,
  output logic                    km_rst_out,
  output logic                    km_data_valid_out,
  output logic [XW-1:0]           km_x_out,
  output logic [YW-1:0]           km_y_out,
  output logic                    km_new_frame_out,
  output logic [NBW-1:0]          km_num_balls_out,
  output logic [MAX_BALLS*XW-1:0] km_seed_x_out,
  output logic [MAX_BALLS*YW-1:0] km_seed_y_out,
  input  logic                    km_done_in,
  input  logic [MAX_BALLS*XW-1:0] km_cx_in,
  input  logic [MAX_BALLS*YW-1:0] km_cy_in,
  output logic                    res_valid_out,
  input  logic                    res_ready_in,
  output logic [MAX_BALLS*XW-1:0] res_x_out,
  output logic [MAX_BALLS*YW-1:0] res_y_out,
  output logic                    timeout_err_out,
  output logic [15:0]             frames_dropped_out
);

  localparam int unsigned SX_W   = MAX_BALLS * XW;
  localparam int unsigned SY_W   = MAX_BALLS * YW;
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

  state_t            state;
  logic              armed;
  logic              warm_valid;
  logic [HOLD_W-1:0] hold_cnt;
  logic [SX_W-1:0]   warm_x;
  logic [SY_W-1:0]   warm_y;
  logic              warm_hit;
  logic [15:0]       dropped_inc;
  logic              wd_load;
  logic              wd_en;
  logic              wd_done;

  // Warm start only when the previous frame converged with the same ball count.
  assign warm_hit    = warm_valid && (num_balls_in == km_num_balls_out);
  assign dropped_inc = (frames_dropped_out == 16'hFFFF) ? frames_dropped_out
                                                        : frames_dropped_out + 16'd1;
  assign wd_load     = (state == STREAM) && frame_start_in;
  assign wd_en       = (state == WAIT);

  kmeans_watchdog #(
    .CNT_W (WD_W)
  ) u_watchdog (
    .clk      (clk_in),
    .rst_n    (rst_n_in),
    .load     (wd_load),
    .load_val (WD_W'(TIMEOUT_CYCLES - 1)),
    .en       (wd_en),
    .done     (wd_done)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state              <= IDLE;
      armed              <= 1'b0;
      warm_valid         <= 1'b0;
      hold_cnt           <= '0;
      warm_x             <= SX_W'(DEF_X);
      warm_y             <= SY_W'(DEF_Y);
      km_rst_out         <= 1'b1;
      km_data_valid_out  <= 1'b0;
      km_x_out           <= '0;
      km_y_out           <= '0;
      km_new_frame_out   <= 1'b0;
      km_num_balls_out   <= '0;
      km_seed_x_out      <= SX_W'(DEF_X);
      km_seed_y_out      <= SY_W'(DEF_Y);
      res_valid_out      <= 1'b0;
      res_x_out          <= SX_W'(DEF_X);
      res_y_out          <= SY_W'(DEF_Y);
      timeout_err_out    <= 1'b0;
      frames_dropped_out <= '0;
    end else begin
      armed             <= 1'b1;
      km_new_frame_out  <= 1'b0;
      km_data_valid_out <= 1'b0;

      case (state)
        IDLE: begin
          km_rst_out <= 1'b1;
          // armed blocks a frame pulse coinciding with reset release
          if (frame_start_in && armed) begin
            km_num_balls_out <= num_balls_in;
            km_seed_x_out    <= warm_hit ? warm_x : SX_W'(DEF_X);
            km_seed_y_out    <= warm_hit ? warm_y : SY_W'(DEF_Y);
            hold_cnt         <= HOLD_W'(RST_HOLD);
            state            <= RESET;
          end
        end

        RESET: begin
          if (hold_cnt <= HOLD_W'(1)) begin
            km_rst_out <= 1'b0;
            state      <= STREAM;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        STREAM: begin
          km_x_out <= pix_x_in;
          km_y_out <= pix_y_in;
          if (frame_start_in) begin
            km_new_frame_out <= 1'b1;
            state            <= WAIT;
          end else begin
            km_data_valid_out <= pix_valid_in;
          end
        end

        WAIT: begin
          if (frame_start_in) begin
            frames_dropped_out <= dropped_inc;
          end
          // convergence takes priority over a coincident watchdog expiry
          if (km_done_in) begin
            res_x_out     <= km_cx_in;
            res_y_out     <= km_cy_in;
            warm_x        <= km_cx_in;
            warm_y        <= km_cy_in;
            warm_valid    <= 1'b1;
            res_valid_out <= 1'b1;
            state         <= PUBLISH;
          end else if (wd_done) begin
            timeout_err_out <= 1'b1;
            warm_valid      <= 1'b0;
            km_rst_out      <= 1'b1;
            state           <= IDLE;
          end
        end

        PUBLISH: begin
          if (res_ready_in) begin
            res_valid_out <= 1'b0;
            km_rst_out    <= 1'b1;
            if (frame_start_in) begin
              km_num_balls_out <= num_balls_in;
              km_seed_x_out    <= warm_hit ? warm_x : SX_W'(DEF_X);
              km_seed_y_out    <= warm_hit ? warm_y : SY_W'(DEF_Y);
              hold_cnt         <= HOLD_W'(RST_HOLD);
              state            <= RESET;
            end else begin
              state <= IDLE;
            end
          end else if (frame_start_in) begin
            frames_dropped_out <= dropped_inc;
          end
        end

        default: begin
          km_rst_out <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kmeans_sequencer.sv
// Scoreboard bench for kmeans_sequencer: the bench plays camera, k_means and consumer,
// predicting pixels, seeds and published results from a frame-level model.
module tb_kmeans_sequencer;

  localparam int unsigned TO   = 100;
  localparam int unsigned HOLD = 2;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        frame_start_in = 1'b0;
  logic        pix_valid_in = 1'b0;
  logic [10:0] pix_x_in = '0;
  logic [9:0]  pix_y_in = '0;
  logic [2:0]  num_balls_in = '0;
  logic        km_done_in = 1'b0;
  logic [87:0] km_cx_in = '0;
  logic [79:0] km_cy_in = '0;
  logic        res_ready_in = 1'b0;

  logic        km_rst_out, km_data_valid_out, km_new_frame_out;
  logic [10:0] km_x_out;
  logic [9:0]  km_y_out;
  logic [2:0]  km_num_balls_out;
  logic [87:0] km_seed_x_out, res_x_out;
  logic [79:0] km_seed_y_out, res_y_out;
  logic        res_valid_out, timeout_err_out;
  logic [15:0] frames_dropped_out;

  kmeans_sequencer #(
    .TIMEOUT_CYCLES (TO),
    .RST_HOLD       (HOLD)
  ) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .frame_start_in     (frame_start_in),
    .pix_valid_in       (pix_valid_in),
    .pix_x_in           (pix_x_in),
    .pix_y_in           (pix_y_in),
    .num_balls_in       (num_balls_in),
    .km_rst_out         (km_rst_out),
    .km_data_valid_out  (km_data_valid_out),
    .km_x_out           (km_x_out),
    .km_y_out           (km_y_out),
    .km_new_frame_out   (km_new_frame_out),
    .km_num_balls_out   (km_num_balls_out),
    .km_seed_x_out      (km_seed_x_out),
    .km_seed_y_out      (km_seed_y_out),
    .km_done_in         (km_done_in),
    .km_cx_in           (km_cx_in),
    .km_cy_in           (km_cy_in),
    .res_valid_out      (res_valid_out),
    .res_ready_in       (res_ready_in),
    .res_x_out          (res_x_out),
    .res_y_out          (res_y_out),
    .timeout_err_out    (timeout_err_out),
    .frames_dropped_out (frames_dropped_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [87:0] x;
    logic [79:0] y;
    logic [2:0]  nb;
  } seed_t;

  typedef struct {
    logic [87:0] x;
    logic [79:0] y;
  } res_t;

  logic [20:0] pix_q[$];
  seed_t       seed_q[$];
  res_t        res_q[$];

  int total = 0;
  int bad = 0;
  int dv_cnt = 0;
  int dv_base = 0;
  logic prev_rst = 1'b1;

  // frame-level reference state
  logic [87:0] def_x;
  logic [79:0] def_y;
  logic        m_warm = 1'b0;
  logic [2:0]  m_prev = '0;
  logic [87:0] m_last_x;
  logic [79:0] m_last_y;
  int          m_dropped = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a pixel, a seed set or a result.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (km_data_valid_out) begin
        dv_cnt++;
        if (pix_q.size() == 0) fail_evt("pix_unexpected");
        else chk("pix", {km_x_out, km_y_out}, pix_q.pop_front());
      end
      if (prev_rst && !km_rst_out) begin
        if (seed_q.size() == 0) fail_evt("seed_unexpected");
        else begin
          seed_t s;
          s = seed_q.pop_front();
          chk("seed_x", km_seed_x_out, s.x);
          chk("seed_y", km_seed_y_out, s.y);
          chk("num_balls", km_num_balls_out, s.nb);
        end
      end
      if (res_valid_out && res_ready_in) begin
        if (res_q.size() == 0) fail_evt("res_unexpected");
        else begin
          res_t r;
          r = res_q.pop_front();
          chk("res_x", res_x_out, r.x);
          chk("res_y", res_y_out, r.y);
        end
      end
    end
    prev_rst = km_rst_out;
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_km_rst"}, km_rst_out, 1);
    chk({tag, "_km_dv"}, km_data_valid_out, 0);
    chk({tag, "_km_xy"}, {km_x_out, km_y_out}, 0);
    chk({tag, "_new_frame"}, km_new_frame_out, 0);
    chk({tag, "_num_balls"}, km_num_balls_out, 0);
    chk({tag, "_seed_x"}, km_seed_x_out, def_x);
    chk({tag, "_seed_y"}, km_seed_y_out, def_y);
    chk({tag, "_res_valid"}, res_valid_out, 0);
    chk({tag, "_res_x"}, res_x_out, def_x);
    chk({tag, "_res_y"}, res_y_out, def_y);
    chk({tag, "_timeout"}, timeout_err_out, 0);
    chk({tag, "_dropped"}, frames_dropped_out, 0);
  endtask

  // Frame pulse taken from IDLE (or PUBLISH with accept); predicts the seeds it loads.
  task automatic start_frame(input logic [2:0] nb, input logic accept);
    seed_t s;
    int cnt = 0;
    if (m_warm && nb == m_prev) begin s.x = m_last_x; s.y = m_last_y; end
    else begin s.x = def_x; s.y = def_y; end
    s.nb = nb;
    seed_q.push_back(s);
    m_prev = nb;
    tick();
    frame_start_in = 1'b1;
    num_balls_in = nb;
    res_ready_in = accept;
    tick();
    frame_start_in = 1'b0;
    res_ready_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      if (km_rst_out) cnt++;
      else break;
    end
    chk("rst_hold", cnt, HOLD);
  endtask

  task automatic stream(input int npix);
    int sent = 0;
    dv_base = dv_cnt;
    while (sent < npix) begin
      tick();
      pix_valid_in = ($urandom_range(0, 3) != 0);
      pix_x_in = 11'($urandom_range(0, 319));
      pix_y_in = 10'($urandom_range(0, 179));
      if (pix_valid_in) begin
        pix_q.push_back({pix_x_in, pix_y_in});
        sent++;
      end
    end
  endtask

  // End-of-frame pulse carries a valid pixel that must be dropped.
  task automatic end_frame(input int npix);
    tick();
    frame_start_in = 1'b1;
    pix_valid_in = 1'b1;
    pix_x_in = 11'($urandom_range(0, 319));
    pix_y_in = 10'($urandom_range(0, 179));
    tick();
    frame_start_in = 1'b0;
    pix_valid_in = 1'b0;
    @(negedge clk_in);
    chk("new_frame_hi", km_new_frame_out, 1);
    chk("drop_pixel", km_data_valid_out, 0);
    @(negedge clk_in);
    chk("new_frame_lo", km_new_frame_out, 0);
    chk("pix_count", dv_cnt - dv_base, npix);
  endtask

  task automatic rand_cents(output logic [87:0] cx, output logic [79:0] cy);
    for (int i = 0; i < 8; i++) begin
      cx[i*11 +: 11] = 11'($urandom_range(0, 319));
      cy[i*10 +: 10] = 10'($urandom_range(0, 179));
    end
  endtask

  task automatic km_done(input int d, input logic [87:0] cx, input logic [79:0] cy);
    res_t r;
    repeat (d) tick();
    km_done_in = 1'b1;
    km_cx_in = cx;
    km_cy_in = cy;
    r.x = cx;
    r.y = cy;
    res_q.push_back(r);
    m_warm = 1'b1;
    m_last_x = cx;
    m_last_y = cy;
    tick();
    km_done_in = 1'b0;
  endtask

  task automatic accept(input int d);
    repeat (d) tick();
    res_ready_in = 1'b1;
    tick();
    res_ready_in = 1'b0;
    @(negedge clk_in);
    chk("valid_after_accept", res_valid_out, 0);
  endtask

  task automatic drop_pulse();
    tick();
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    m_dropped++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [87:0] cx;
    logic [79:0] cy;
    int cycles;
    logic saw_valid;
    for (int i = 0; i < 8; i++) begin
      def_x[i*11 +: 11] = 11'(20 + 40 * i);
      def_y[i*10 +: 10] = 10'd90;
    end

    #12;
    chk_reset("por");

    // Frame pulse coincident with reset release must be ignored.
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    repeat (4) @(negedge clk_in);
    chk("release_pulse_ignored", km_rst_out, 1);

    // Frame A: cold start, 10 pixels, held result with cx[0]=133.
    start_frame(3'd2, 1'b0);
    stream(10);
    end_frame(10);
    rand_cents(cx, cy);
    cx[10:0] = 11'd133;
    km_done(3, cx, cy);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      chk("hold_valid", res_valid_out, 1);
      chk("hold_x0", res_x_out[10:0], 133);
    end
    tick();
    accept(0);
    chk("idle_rst", km_rst_out, 1);

    // Frame B: warm seeds, three drops in WAIT, one in PUBLISH.
    start_frame(3'd2, 1'b0);
    chk("warm_seed_x0", km_seed_x_out[10:0], 133);
    stream(6);
    end_frame(6);
    repeat (3) drop_pulse();
    @(negedge clk_in);
    chk("dropped_wait", frames_dropped_out, m_dropped);
    chk("no_restart_dv", km_data_valid_out, 0);
    chk("no_restart_rst", km_rst_out, 0);
    rand_cents(cx, cy);
    km_done(2, cx, cy);
    drop_pulse();
    @(negedge clk_in);
    chk("dropped_publish", frames_dropped_out, m_dropped);
    chk("publish_held", res_valid_out, 1);

    // Frame C: accepted and restarted in one cycle with a new ball count.
    start_frame(3'd4, 1'b1);
    chk("cold_seed_x0", km_seed_x_out[10:0], 20);
    stream(5);
    end_frame(5);
    rand_cents(cx, cy);
    km_done(TO - 2, cx, cy);
    @(negedge clk_in);
    chk("done_beats_timeout_valid", res_valid_out, 1);
    chk("done_beats_timeout_err", timeout_err_out, 0);
    accept(1);

    // Frame D: watchdog expiry.
    start_frame(3'd4, 1'b0);
    stream(4);
    end_frame(4);
    cycles = 1;
    saw_valid = 1'b0;
    while (cycles < 3 * TO && !timeout_err_out) begin
      @(negedge clk_in);
      cycles++;
      if (res_valid_out) saw_valid = 1'b1;
    end
    chk("timeout_cycles", cycles, TO);
    chk("timeout_no_publish", saw_valid, 0);
    chk("timeout_idle_rst", km_rst_out, 1);
    m_warm = 1'b0;

    // Randomised frames; ball count repeats often so warm starts are exercised.
    for (int f = 0; f < 6; f++) begin
      int np;
      start_frame(3'($urandom_range(4, 5)), 1'b0);
      np = $urandom_range(1, 8);
      stream(np);
      end_frame(np);
      rand_cents(cx, cy);
      km_done($urandom_range(0, 20), cx, cy);
      accept($urandom_range(0, 4));
    end
    chk("sticky_timeout", timeout_err_out, 1);
    chk("pix_q_empty", pix_q.size(), 0);
    chk("seed_q_empty", seed_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);

    // Asynchronous reset in the middle of streaming, away from any clock edge.
    start_frame(3'd5, 1'b0);
    tick();
    pix_valid_in = 1'b1;
    #2;
    rst_n_in = 1'b0;
    #1;
    chk_reset("async");
    pix_valid_in = 1'b0;
    pix_q.delete();
    seed_q.delete();
    res_q.delete();
    m_warm = 1'b0;
    m_dropped = 0;
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
